// File: rtl/mdl_syncdet_if.sv
// Bundle of the sync-detector's control/data inputs and status outputs.
// The detector connects via the slave modport; the driving logic uses master.
interface mdl_syncdet_if;
  logic        i_CLK2M_PCEN_n;
  logic        i_BIT_STB_n;
  logic        i_BDI;
  logic        i_SEARCH_START_n;
  logic        i_BMODE_n;
  logic        o_SYNCED_FLAG_SET_n;
  logic        o_SEARCHING;
  logic        o_SYNC_TIMEOUT;
  logic [11:0] o_BITCNT;

  modport master (
    output i_CLK2M_PCEN_n, i_BIT_STB_n, i_BDI, i_SEARCH_START_n, i_BMODE_n,
    input  o_SYNCED_FLAG_SET_n, o_SEARCHING, o_SYNC_TIMEOUT, o_BITCNT
  );

  modport slave (
    input  i_CLK2M_PCEN_n, i_BIT_STB_n, i_BDI, i_SEARCH_START_n, i_BMODE_n,
    output o_SYNCED_FLAG_SET_n, o_SEARCHING, o_SYNC_TIMEOUT, o_BITCNT
  );
endinterface

// File: rtl/mdl_syncdet.sv
// Bootloader sync-word detector: slides a 16-bit window over the serial bubble
// data and emits a one-tick active-low strobe on match, with a bit-count timeout.
module mdl_syncdet #(
  parameter logic [15:0] SYNC_PATTERN = 16'hFD3A,
  parameter int          SEARCH_LIMIT = 2053
) (
  input logic          i_MCLK,
  input logic          i_SYS_RST,
  mdl_syncdet_if.slave bus
);

  localparam logic [11:0] LIMIT = 12'(SEARCH_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] shreg_reg, shreg_next;
  logic [4:0]  fill_reg, fill_next;
  logic [11:0] bitcnt_reg, bitcnt_next;
  logic        strobe_n_reg, strobe_n_next;
  logic        timeout_reg, timeout_next;

  logic        tick;
  logic        start_req;
  logic [15:0] shifted;
  logic [4:0]  fill_inc;
  logic [11:0] bitcnt_inc;
  logic        match;

  assign tick       = ~bus.i_CLK2M_PCEN_n;
  assign start_req  = ~bus.i_SEARCH_START_n & ~bus.i_BMODE_n;
  assign shifted    = {shreg_reg[14:0], bus.i_BDI};
  assign fill_inc   = (fill_reg == 5'd16) ? 5'd16 : fill_reg + 5'd1;
  assign bitcnt_inc = bitcnt_reg + 12'd1;
  // A full window is required, so leading zeros can never fake a match.
  assign match      = (fill_inc == 5'd16) && (shifted == SYNC_PATTERN);

  always_ff @(posedge i_MCLK or posedge i_SYS_RST) begin
    if (i_SYS_RST) begin
      state_reg    <= ST_IDLE;
      shreg_reg    <= 16'd0;
      fill_reg     <= 5'd0;
      bitcnt_reg   <= 12'd0;
      strobe_n_reg <= 1'b1;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      fill_reg     <= fill_next;
      bitcnt_reg   <= bitcnt_next;
      strobe_n_reg <= strobe_n_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    shreg_next    = shreg_reg;
    fill_next     = fill_reg;
    bitcnt_next   = bitcnt_reg;
    timeout_next  = timeout_reg;
    // Strobe is released on every tick unless a match re-asserts it below.
    strobe_n_next = tick ? 1'b1 : strobe_n_reg;
    if (tick) begin
      if (start_req) begin
        state_next   = ST_SEARCH;
        shreg_next   = 16'd0;
        fill_next    = 5'd0;
        bitcnt_next  = 12'd0;
        timeout_next = 1'b0;
      end else if (state_reg == ST_SEARCH) begin
        if (bus.i_BMODE_n) begin
          state_next = ST_IDLE;
        end else if (!bus.i_BIT_STB_n) begin
          shreg_next  = shifted;
          fill_next   = fill_inc;
          bitcnt_next = bitcnt_inc;
          if (match) begin
            state_next    = ST_LOCKED;
            strobe_n_next = 1'b0;
          end else if (bitcnt_inc == LIMIT) begin
            state_next   = ST_TIMEOUT;
            timeout_next = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    bus.o_SYNCED_FLAG_SET_n = strobe_n_reg;
    bus.o_SEARCHING         = (state_reg == ST_SEARCH);
    bus.o_SYNC_TIMEOUT      = timeout_reg;
    bus.o_BITCNT            = bitcnt_reg;
  end

endmodule

// File: tb/tb_mdl_syncdet.sv
// Directed bench for mdl_syncdet: three instances (limits 2053/40/16) share
// one stimulus stream; a per-tick reference model feeds a scoreboard queue.
module tb_mdl_syncdet;
  localparam int          NDUT = 3;
  localparam int          LIM [NDUT] = '{2053, 40, 16};
  localparam logic [15:0] PAT = 16'hFD3A;

  localparam int S_IDLE = 0, S_SEARCH = 1, S_LOCKED = 2, S_TIMEOUT = 3;

  typedef struct packed {
    logic        strobe_n;
    logic        searching;
    logic        timeout;
    logic [11:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pcen_n = 1'b1, stb_n = 1'b1, bdi = 1'b0, start_n = 1'b1, bmode_n = 1'b1;

  always #5 clk = ~clk;

  logic [NDUT-1:0] obs_strobe, obs_search, obs_to;
  logic [11:0]     obs_cnt [NDUT];

  mdl_syncdet_if bus [NDUT] ();

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    assign bus[gi].i_CLK2M_PCEN_n   = pcen_n;
    assign bus[gi].i_BIT_STB_n      = stb_n;
    assign bus[gi].i_BDI            = bdi;
    assign bus[gi].i_SEARCH_START_n = start_n;
    assign bus[gi].i_BMODE_n        = bmode_n;
    assign obs_strobe[gi] = bus[gi].o_SYNCED_FLAG_SET_n;
    assign obs_search[gi] = bus[gi].o_SEARCHING;
    assign obs_to[gi]     = bus[gi].o_SYNC_TIMEOUT;
    assign obs_cnt[gi]    = bus[gi].o_BITCNT;

    mdl_syncdet #(.SYNC_PATTERN(PAT), .SEARCH_LIMIT(LIM[gi])) u_dut (
      .i_MCLK    (clk),
      .i_SYS_RST (rst),
      .bus       (bus[gi].slave)
    );
  end

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_st  [NDUT];
  logic [15:0] m_win [NDUT];
  int          m_cnt [NDUT];
  logic        m_stb [NDUT];
  logic        m_to  [NDUT];
  int          strobes [NDUT];
  logic        prev_stb [NDUT];
  exp_t        sb_q [$];

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_st[d] = S_IDLE; m_win[d] = 16'd0; m_cnt[d] = 0; m_stb[d] = 1'b1; m_to[d] = 1'b0;
      prev_stb[d] = 1'b1;
    end
  endtask

  task automatic clr_strobes();
    for (int d = 0; d < NDUT; d++) strobes[d] = 0;
  endtask

  task automatic model_step(input int d, input logic tk, input logic sb, input logic b,
                            input logic st, input logic bm);
    if (!tk) return;
    m_stb[d] = 1'b1;
    if (st && !bm) begin
      m_st[d] = S_SEARCH; m_win[d] = 16'd0; m_cnt[d] = 0; m_to[d] = 1'b0;
    end else if (m_st[d] == S_SEARCH) begin
      if (bm) m_st[d] = S_IDLE;
      else if (sb) begin
        m_win[d] = {m_win[d][14:0], b};
        m_cnt[d] = m_cnt[d] + 1;
        if (m_cnt[d] >= 16 && m_win[d] == PAT) begin
          m_st[d] = S_LOCKED; m_stb[d] = 1'b0;
        end else if (m_cnt[d] == LIM[d]) begin
          m_st[d] = S_TIMEOUT; m_to[d] = 1'b1;
        end
      end
    end
  endtask

  // One MCLK cycle: drive, predict, clock, compare every instance.
  task automatic cyc(input logic tk, input logic sb, input logic b, input logic st, input logic bm);
    exp_t e;
    pcen_n = ~tk; stb_n = ~sb; bdi = b; start_n = ~st; bmode_n = bm;
    for (int d = 0; d < NDUT; d++) begin
      model_step(d, tk, sb, b, st, bm);
      e.strobe_n  = m_stb[d];
      e.searching = (m_st[d] == S_SEARCH);
      e.timeout   = m_to[d];
      e.cnt       = 12'(m_cnt[d]);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      e = sb_q.pop_front();
      chk($sformatf("sb%0d_strobe", d), {11'd0, obs_strobe[d]}, {11'd0, e.strobe_n});
      chk($sformatf("sb%0d_search", d), {11'd0, obs_search[d]}, {11'd0, e.searching});
      chk($sformatf("sb%0d_timeout", d), {11'd0, obs_to[d]}, {11'd0, e.timeout});
      chk($sformatf("sb%0d_cnt", d), obs_cnt[d], e.cnt);
      if (prev_stb[d] && !obs_strobe[d]) strobes[d]++;
      prev_stb[d] = obs_strobe[d];
    end
    $display("cyc tick=%0b stb=%0b bdi=%0b start=%0b bm=%0b -> cnt=%0d/%0d/%0d flag_n=%b",
             tk, sb, b, st, bm, obs_cnt[0], obs_cnt[1], obs_cnt[2], obs_strobe);
  endtask

  // Bits w[hi] down to w[lo], each followed by a non-tick edge carrying a decoy bit.
  task automatic send_bits(input logic [15:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cyc(1'b1, 1'b1, w[i], 1'b0, 1'b0);
      cyc(1'b0, 1'b1, ~w[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] pw;
    logic [15:0] rnd;
    pw = PAT;
    model_reset();
    clr_strobes();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobe", {11'd0, obs_strobe[0]}, 12'd1);
    chk("rst_search", {11'd0, obs_search[0]}, 12'd0);
    chk("rst_timeout", {11'd0, obs_to[0]}, 12'd0);
    chk("rst_cnt", obs_cnt[0], 12'd0);
    rst = 1'b0;

    // 1/4: pattern right after start; limit-16 instance matches on its limit bit
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(pw, 15, 0);
    chk("t1_strobes0", 12'(strobes[0]), 12'd1);
    chk("t1_cnt0", obs_cnt[0], 12'd16);
    chk("t1_search0", {11'd0, obs_search[0]}, 12'd0);
    chk("t4_strobes2", 12'(strobes[2]), 12'd1);
    chk("t4_timeout2", {11'd0, obs_to[2]}, 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_release0", {11'd0, obs_strobe[0]}, 12'd1);

    // 2: five random bits, then the pattern
    clr_strobes();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rnd = 16'($urandom);
    send_bits(rnd, 4, 0);
    send_bits(pw, 15, 0);
    chk("t2_strobes0", 12'(strobes[0]), 12'd1);
    chk("t2_cnt0", obs_cnt[0], 12'd21);
    chk("t2_strobes2", 12'(strobes[2]), 12'd0);
    chk("t2_timeout2", {11'd0, obs_to[2]}, 12'd1);

    // 3: all-zero stream times out the limit-40 instance
    clr_strobes();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_clr_to2", {11'd0, obs_to[2]}, 12'd0);
    for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_timeout1", {11'd0, obs_to[1]}, 12'd1);
    chk("t3_cnt1", obs_cnt[1], 12'd40);
    chk("t3_search0", {11'd0, obs_search[0]}, 12'd1);
    chk("t3_strobes1", 12'(strobes[1]), 12'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_restart_to1", {11'd0, obs_to[1]}, 12'd0);
    chk("t3_restart_cnt1", obs_cnt[1], 12'd0);

    // Restart with a bit strobe on the same tick: strobe discarded
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("restart_cnt0", obs_cnt[0], 12'd0);

    // 5: abort after 10 bits, then finish the pattern; start with BMODE_n=1 ignored
    clr_strobes();
    send_bits(pw, 15, 6);
    cyc(1'b1, 1'b1, pw[5], 1'b0, 1'b1);
    chk("t5_abort_search0", {11'd0, obs_search[0]}, 12'd0);
    send_bits(pw, 5, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_bits(pw, 15, 0);
    chk("t5_strobes0", 12'(strobes[0]), 12'd0);
    chk("t5_search0", {11'd0, obs_search[0]}, 12'd0);
    chk("t5_cnt0", obs_cnt[0], 12'd10);
    chk("t5_timeout0", {11'd0, obs_to[0]}, 12'd0);

    // 6: async reset after bit 15, then deliver bit 16
    clr_strobes();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(pw, 15, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_search0", {11'd0, obs_search[0]}, 12'd0);
    chk("t6_rst_cnt0", obs_cnt[0], 12'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, pw[0], 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_strobes0", 12'(strobes[0]), 12'd0);
    chk("t6_strobe0", {11'd0, obs_strobe[0]}, 12'd1);
    chk("t6_timeout0", {11'd0, obs_to[0]}, 12'd0);
    chk("t6_cnt0", obs_cnt[0], 12'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdl_syncdet.md
Name: mdl_syncdet

Overview:
Bootloader sync-pattern detector. It sits directly upstream of the access-mode flag logic and produces the active-low SYNCED_FLAG_SET_n strobe that moves the address-latch source from bootloader to user. It is armed by a search-start command while bootloader mode is active. It shifts in the serial bubble detector data one bit per bit strobe and compares a sliding window against a fixed sync word. It also bounds the search with a bit-count timeout.

Parameters:
SYNC_PATTERN, 16'hFD3A, sync word; the MSB is the oldest bit received.
SEARCH_LIMIT, 2053, maximum number of bits examined per search before timeout (1..4095).

Ports:
i_MCLK  in  1  master clock
i_SYS_RST  in  1  asynchronous reset, active-high
i_CLK2M_PCEN_n  in  1  clock enable, active-low; all state updates occur only on i_MCLK rising edges where this is 0 ("tick")
i_BIT_STB_n  in  1  active-low; on a tick, a valid detector bit is present on i_BDI
i_BDI  in  1  serial bubble detector data
i_SEARCH_START_n  in  1  active-low search start/restart command, sampled on ticks
i_BMODE_n  in  1  bootloader mode flag (0 = bootloader mode); searching is allowed only while 0
o_SYNCED_FLAG_SET_n  out  1  active-low sync-found strobe, one tick wide
o_SEARCHING  out  1  high while in SEARCH
o_SYNC_TIMEOUT  out  1  sticky timeout flag
o_BITCNT  out  12  bits examined in the current or last search

Behaviour:
- Reset (async, i_SYS_RST=1):
  - state=IDLE, shift register=0, fill count=0, o_BITCNT=0.
  - o_SYNCED_FLAG_SET_n=1, o_SEARCHING=0, o_SYNC_TIMEOUT=0.
  - Reset asserted mid-search aborts immediately; no strobe is produced.
- Non-tick MCLK edges: every register holds.
- States: IDLE, SEARCH, LOCKED, TIMEOUT. o_SEARCHING = (state==SEARCH).
- Start, any state:
  - If i_SEARCH_START_n=0 and i_BMODE_n=0 on a tick: next state=SEARCH; clear shift register, fill count and o_BITCNT; clear o_SYNC_TIMEOUT.
  - The bit strobe on the start tick is ignored.
  - Start with i_BMODE_n=1 is ignored.
- SEARCH, tick with i_BIT_STB_n=0:
  - shreg <= {shreg[14:0], i_BDI}.
  - fill count saturates at 16.
  - o_BITCNT increments by 1.
- Match: evaluated on the post-shift value in the same tick. Requires (fill after shift)==16 and shifted value==SYNC_PATTERN.
  - On match: next state=LOCKED, and o_SYNCED_FLAG_SET_n=0 for exactly the next tick period. It returns to 1 at the following tick.
  - Latency: strobe low starting at the MCLK edge of the tick that samples the final pattern bit.
- Timeout: if incremented o_BITCNT==SEARCH_LIMIT and no match on that bit, next state=TIMEOUT and o_SYNC_TIMEOUT=1.
  - Match on the limit bit wins; no timeout in that case.
- Abort: i_BMODE_n=1 during SEARCH returns to IDLE on that tick, with no strobe and no timeout. Abort takes priority over a bit strobe on the same tick, which is discarded.
- Start while in SEARCH: restarts with cleared state; it takes priority over a bit strobe on the same tick.
- LOCKED and TIMEOUT: hold until a start or reset. Bit strobes are ignored and o_BITCNT is frozen.
- The window does not match before 16 bits have been received, even if the residual zeros plus partial data equal the pattern.
- o_BITCNT never wraps: SEARCH_LIMIT ≤ 4095 and counting stops outside SEARCH.

Test Plan:
1. Reset then BMODE_n=0, start, feed 16'hFD3A MSB-first on 16 strobes -> strobe low for exactly one tick at bit 16; state LOCKED; o_BITCNT=16; o_SEARCHING=0.
2. Feed 5 random bits then the pattern -> strobe at bit 21 only; no strobe on the earlier partial windows; o_BITCNT=21.
3. SEARCH_LIMIT=40, feed all-zero bits -> o_SYNC_TIMEOUT=1 at bit 40, no strobe; a new start clears the timeout and o_BITCNT.
4. SEARCH_LIMIT=16, pattern ends exactly on bit 16 -> strobe, o_SYNC_TIMEOUT stays 0.
5. After 10 bits, raise i_BMODE_n -> IDLE, no strobe; completing the pattern afterwards produces nothing. Start with i_BMODE_n=1 is ignored.
6. Assert i_SYS_RST after bit 15 of the pattern, release, deliver bit 16 -> no strobe; all outputs at reset values. Strobes on non-tick MCLK edges are never sampled.
